// File: rtl/spi_responder_pkg.sv
// spi_responder_pkg: protocol command codes and FSM state encodings.
// Shared by the responder top and the testbench.
// State constants are plain 3-bit localparams for legacy tool compatibility.
package spi_responder_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_ID    = 8'h9F;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CMD     = 3'd1;
  localparam logic [2:0] ST_ADDR    = 3'd2;
  localparam logic [2:0] ST_DATA_WR = 3'd3;
  localparam logic [2:0] ST_DATA_RD = 3'd4;
  localparam logic [2:0] ST_DATA_ID = 3'd5;
  localparam logic [2:0] ST_IGNORE  = 3'd6;

endpackage

// File: rtl/spi_responder_if.sv
// spi_responder_if: SPI pins plus the local read port and write report.
// "slave" is the responder side, "master" is the initiator/host side.
// Signal names follow the board pin names.
interface spi_responder_if #(parameter int ADDR_W = 4);

  logic              SCK;
  logic              MOSI;
  logic              nSS;
  logic              MISO;
  logic              MISO_OE;
  logic [ADDR_W-1:0] LADDR;
  logic [7:0]        LDATA;
  logic              WSTB;
  logic [ADDR_W-1:0] WADDR;
  logic [7:0]        WDATA;

  modport slave (
    input  SCK, MOSI, nSS, LADDR,
    output MISO, MISO_OE, LDATA, WSTB, WADDR, WDATA
  );

  modport master (
    output SCK, MOSI, nSS, LADDR,
    input  MISO, MISO_OE, LDATA, WSTB, WADDR, WDATA
  );

endinterface

// File: rtl/spi_responder_sync.sv
// spi_sync: 2-flop synchronizer for an asynchronous pin, plus one history flop.
// Level is valid 2 CLK after the pin; rise/fall pulses are combinational
// from the synchronized level so the consumer acts on the 3rd CLK edge.
module spi_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic s3_q, s3_d;

  // next-state: plain shift through the three stages
  always_comb begin
    s1_d = d;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  // synchronizer and history flops, reset to the pin's idle level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
      s3_q <= RST_VAL;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign lvl  = s2_q;
  assign rise = s2_q & ~s3_q;
  assign fall = ~s2_q & s3_q;

endmodule

// File: rtl/spi_responder.sv
// spi_responder: SPI mode-0 responder with command/address/data protocol
// over a 2^ADDR_W byte register file with auto-incrementing pointer.
// Pins are oversampled; every action lands 3 CLK after the pin edge.
module spi_responder
  import spi_responder_pkg::*;
#(
  parameter int         ADDR_W  = 4,
  parameter logic [7:0] ID_BYTE = 8'hA5
) (
  input  logic           CLK,
  input  logic           RST,
  spi_responder_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;

  logic sck_lvl, sck_rise, sck_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;
  logic ss_lvl, ss_rise, ss_fall;
  logic unused_sync;

  spi_sync #(.RST_VAL(1'b0)) u_sync_sck (
    .clk(CLK), .rst(RST), .d(bus.SCK), .lvl(sck_lvl), .rise(sck_rise), .fall(sck_fall)
  );
  spi_sync #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk(CLK), .rst(RST), .d(bus.MOSI), .lvl(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall)
  );
  spi_sync #(.RST_VAL(1'b1)) u_sync_ss (
    .clk(CLK), .rst(RST), .d(bus.nSS), .lvl(ss_lvl), .rise(ss_rise), .fall(ss_fall)
  );

  assign unused_sync = ^{sck_lvl, mosi_rise, mosi_fall, ss_lvl};

  logic [2:0]        state_q, state_d;
  logic [2:0]        bitcnt_q, bitcnt_d;
  logic [7:0]        rx_q, rx_d;
  logic [7:0]        tx_q, tx_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              op_rd_q, op_rd_d;
  logic              miso_q, miso_d;
  logic              oe_q, oe_d;
  logic              wstb_q, wstb_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [7:0]        regs_q [DEPTH];
  logic [7:0]        regs_d [DEPTH];
  logic [7:0]        rx_byte;

  // protocol FSM: nSS edges dominate, then SCK rise (capture) / fall (shift out)
  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    rx_d     = rx_q;
    tx_d     = tx_q;
    ptr_d    = ptr_q;
    op_rd_d  = op_rd_q;
    miso_d   = miso_q;
    oe_d     = oe_q;
    wstb_d   = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    regs_d   = regs_q;
    rx_byte  = {rx_q[6:0], mosi_lvl};

    if (ss_rise) begin
      // deselect drops any partial byte and the pointer context
      state_d  = ST_IDLE;
      bitcnt_d = 3'd0;
      oe_d     = 1'b0;
      miso_d   = 1'b1;
    end else if (ss_fall) begin
      state_d  = ST_CMD;
      bitcnt_d = 3'd0;
      oe_d     = 1'b1;
      miso_d   = 1'b1;
      tx_d     = 8'hFF;
    end else if (state_q != ST_IDLE) begin
      if (sck_rise) begin
        rx_d     = rx_byte;
        bitcnt_d = bitcnt_q + 3'd1;
        if (bitcnt_q == 3'd7) begin
          case (state_q)
            ST_CMD: begin
              case (rx_byte)
                CMD_WRITE: begin state_d = ST_ADDR; op_rd_d = 1'b0; end
                CMD_READ:  begin state_d = ST_ADDR; op_rd_d = 1'b1; end
                CMD_ID:    state_d = ST_DATA_ID;
                default:   state_d = ST_IGNORE;
              endcase
            end
            ST_ADDR: begin
              ptr_d   = rx_byte[ADDR_W-1:0];
              state_d = op_rd_q ? ST_DATA_RD : ST_DATA_WR;
            end
            ST_DATA_WR: begin
              regs_d[ptr_q] = rx_byte;
              waddr_d       = ptr_q;
              wdata_d       = rx_byte;
              wstb_d        = 1'b1;
              ptr_d         = ptr_q + 1'b1;
            end
            default: ;
          endcase
        end
      end else if (sck_fall) begin
        // bitcnt==0 here means this is the 8th fall of the byte just finished
        if (bitcnt_q == 3'd0) begin
          case (state_q)
            ST_DATA_RD: begin
              tx_d  = regs_q[ptr_q];
              ptr_d = ptr_q + 1'b1;
            end
            ST_DATA_ID: tx_d = ID_BYTE;
            default:    tx_d = 8'hFF;
          endcase
        end else begin
          tx_d = {tx_q[6:0], 1'b1};
        end
        miso_d = (state_q == ST_IGNORE) ? 1'b1 : tx_d[7];
      end
    end
  end

  // state registers and register file
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      bitcnt_q <= 3'd0;
      rx_q     <= 8'h00;
      tx_q     <= 8'hFF;
      ptr_q    <= '0;
      op_rd_q  <= 1'b0;
      miso_q   <= 1'b1;
      oe_q     <= 1'b0;
      wstb_q   <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= 8'h00;
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= 8'h00;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      rx_q     <= rx_d;
      tx_q     <= tx_d;
      ptr_q    <= ptr_d;
      op_rd_q  <= op_rd_d;
      miso_q   <= miso_d;
      oe_q     <= oe_d;
      wstb_q   <= wstb_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign bus.MISO    = miso_q;
  assign bus.MISO_OE = oe_q;
  assign bus.WSTB    = wstb_q;
  assign bus.WADDR   = waddr_q;
  assign bus.WDATA   = wdata_q;
  assign bus.LDATA   = regs_q[bus.LADDR];

endmodule

// File: tb/tb_spi_responder.sv
// tb_spi_responder: bit-bangs SPI transactions at 12 CLK per SCK period and
// checks MISO bytes, write strobes and the local read port against a
// byte-level reference model of the register file.
module tb_spi_responder;
  import spi_responder_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_responder_if #(.ADDR_W(4)) bus ();

  spi_responder #(.ADDR_W(4), .ID_BYTE(8'hA5)) dut (
    .CLK(clk), .RST(rst), .bus(bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int unstable = 0;
  int wstb_wide = 0;
  logic wstb_prev = 1'b0;

  logic [7:0]  mem_m [16];
  logic [11:0] obs_wr [$];
  logic [11:0] exp_wr [$];
  logic [7:0]  txn_b [$];
  logic [7:0]  rx_b [$];
  logic [7:0]  exp_rx [$];
  bit          exp_chk [$];

  // write-strobe monitor, sampled on the falling CLK edge
  always @(negedge clk) begin
    if (bus.WSTB === 1'b1) obs_wr.push_back({bus.WADDR, bus.WDATA});
    if (bus.WSTB === 1'b1 && wstb_prev) wstb_wide++;
    wstb_prev = (bus.WSTB === 1'b1);
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, output logic m);
    logic m1;
    bus.MOSI = b;
    wait_clk(6);
    m = bus.MISO;
    bus.SCK = 1'b1;
    wait_clk(3);
    m1 = bus.MISO;
    if (m1 !== m) unstable++;
    wait_clk(3);
    bus.SCK = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic [7:0] r);
    logic m;
    for (int i = 7; i >= 0; i--) begin
      send_bit(b[i], m);
      r[i] = m;
    end
  endtask

  task automatic spi_txn();
    logic [7:0] r;
    rx_b.delete();
    bus.nSS = 1'b0;
    wait_clk(6);
    foreach (txn_b[i]) begin
      send_byte(txn_b[i], r);
      rx_b.push_back(r);
    end
    wait_clk(6);
    bus.nSS = 1'b1;
    wait_clk(8);
  endtask

  // byte-level model: what a whole transaction should do to memory and MISO
  function automatic void model_txn();
    logic [3:0] p;
    logic [7:0] e;
    bit c;
    p = 4'd0;
    exp_rx.delete();
    exp_chk.delete();
    for (int i = 0; i < txn_b.size(); i++) begin
      e = 8'hFF;
      c = 1'b0;
      case (txn_b[0])
        8'h02: begin
          if (i == 1) p = txn_b[1][3:0];
          else if (i >= 2) begin
            mem_m[p] = txn_b[i];
            exp_wr.push_back({p, txn_b[i]});
            p = p + 4'd1;
          end
        end
        8'h03: begin
          if (i == 1) p = txn_b[1][3:0];
          else if (i >= 2) begin
            e = mem_m[p];
            c = 1'b1;
            p = p + 4'd1;
          end
        end
        8'h9F:   if (i >= 1) begin e = 8'hA5; c = 1'b1; end
        default: if (i >= 1) c = 1'b1;
      endcase
      exp_rx.push_back(e);
      exp_chk.push_back(c);
    end
  endfunction

  task automatic test_reset();
    bus.nSS = 1'b1; bus.SCK = 1'b0; bus.MOSI = 1'b0; bus.LADDR = 4'd0;
    rst = 1'b1;
    wait_clk(4);
    rst = 1'b0;
    wait_clk(5);
    n_cmp++; if (bus.MISO !== 1'b1) begin n_err++; $display("FAIL reset_miso got=%b exp=1", bus.MISO); end
    n_cmp++; if (bus.MISO_OE !== 1'b0) begin n_err++; $display("FAIL reset_oe got=%b exp=0", bus.MISO_OE); end
    n_cmp++; if (bus.WSTB !== 1'b0) begin n_err++; $display("FAIL reset_wstb got=%b exp=0", bus.WSTB); end
    n_cmp++; if ({bus.WADDR, bus.WDATA} !== 12'h000) begin n_err++; $display("FAIL reset_waddr_wdata got=%h exp=000", {bus.WADDR, bus.WDATA}); end
    for (int a = 0; a < 16; a++) begin
      mem_m[a] = 8'h00;
      bus.LADDR = a[3:0]; #1;
      n_cmp++; if (bus.LDATA !== 8'h00) begin n_err++; $display("FAIL reset_reg[%0d] got=%h exp=00", a, bus.LDATA); end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [7:0] r;
    logic m;
    txn_b = '{8'h02, 8'h01, 8'h5A};
    spi_txn(); model_txn();
    bus.nSS = 1'b0;
    wait_clk(6);
    send_byte(8'h02, r);
    send_byte(8'h01, r);
    for (int i = 0; i < 5; i++) send_bit(1'b1, m);
    rst = 1'b1;
    wait_clk(2);
    n_cmp++; if ({bus.MISO, bus.MISO_OE, bus.WSTB} !== 3'b100) begin n_err++; $display("FAIL rstmid_pins got=%b exp=100", {bus.MISO, bus.MISO_OE, bus.WSTB}); end
    n_cmp++; if ({bus.WADDR, bus.WDATA} !== 12'h000) begin n_err++; $display("FAIL rstmid_wlast got=%h exp=000", {bus.WADDR, bus.WDATA}); end
    bus.nSS = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(6);
    n_cmp++; if (bus.MISO_OE !== 1'b0) begin n_err++; $display("FAIL rstmid_oe_after got=%b exp=0", bus.MISO_OE); end
    for (int a = 0; a < 16; a++) begin
      mem_m[a] = 8'h00;
      bus.LADDR = a[3:0]; #1;
      n_cmp++; if (bus.LDATA !== 8'h00) begin n_err++; $display("FAIL rstmid_reg[%0d] got=%h exp=00", a, bus.LDATA); end
    end
    @(negedge clk);
    obs_wr.delete(); exp_wr.delete();
  endtask

  task automatic test_write_basic();
    obs_wr.delete(); exp_wr.delete();
    txn_b = '{8'h02, 8'h03, 8'h11, 8'h22};
    spi_txn(); model_txn();
    n_cmp++; if (obs_wr.size() !== 2) begin n_err++; $display("FAIL wr_count got=%0d exp=2", obs_wr.size()); end
    else begin
      n_cmp++; if (obs_wr[0] !== 12'h311) begin n_err++; $display("FAIL wr_first got=%h exp=311", obs_wr[0]); end
      n_cmp++; if (obs_wr[1] !== 12'h422) begin n_err++; $display("FAIL wr_second got=%h exp=422", obs_wr[1]); end
    end
    bus.LADDR = 4'd3; #1;
    n_cmp++; if (bus.LDATA !== 8'h11) begin n_err++; $display("FAIL wr_ldata3 got=%h exp=11", bus.LDATA); end
    bus.LADDR = 4'd4; #1;
    n_cmp++; if (bus.LDATA !== 8'h22) begin n_err++; $display("FAIL wr_ldata4 got=%h exp=22", bus.LDATA); end
    @(negedge clk);
  endtask

  task automatic test_read_basic();
    obs_wr.delete(); unstable = 0;
    txn_b = '{8'h03, 8'h03, 8'h00, 8'hFF};
    spi_txn(); model_txn();
    n_cmp++; if (rx_b[2] !== 8'h11) begin n_err++; $display("FAIL rd_byte0 got=%h exp=11", rx_b[2]); end
    n_cmp++; if (rx_b[3] !== 8'h22) begin n_err++; $display("FAIL rd_byte1 got=%h exp=22", rx_b[3]); end
    n_cmp++; if (unstable !== 0) begin n_err++; $display("FAIL rd_miso_stable got=%0d exp=0", unstable); end
    n_cmp++; if (obs_wr.size() !== 0) begin n_err++; $display("FAIL rd_no_wstb got=%0d exp=0", obs_wr.size()); end
  endtask

  task automatic test_wrap();
    obs_wr.delete(); exp_wr.delete();
    txn_b = '{8'h02, 8'hFF, 8'hAA, 8'hBB};
    spi_txn(); model_txn();
    n_cmp++; if (obs_wr.size() !== 2) begin n_err++; $display("FAIL wrap_count got=%0d exp=2", obs_wr.size()); end
    else begin
      n_cmp++; if (obs_wr[0] !== 12'hFAA) begin n_err++; $display("FAIL wrap_first got=%h exp=FAA", obs_wr[0]); end
      n_cmp++; if (obs_wr[1] !== 12'h0BB) begin n_err++; $display("FAIL wrap_second got=%h exp=0BB", obs_wr[1]); end
    end
    bus.LADDR = 4'hF; #1;
    n_cmp++; if (bus.LDATA !== 8'hAA) begin n_err++; $display("FAIL wrap_ldataF got=%h exp=AA", bus.LDATA); end
    bus.LADDR = 4'h0; #1;
    n_cmp++; if (bus.LDATA !== 8'hBB) begin n_err++; $display("FAIL wrap_ldata0 got=%h exp=BB", bus.LDATA); end
    @(negedge clk);
    txn_b = '{8'h03, 8'h0F, 8'h00, 8'h00};
    spi_txn(); model_txn();
    n_cmp++; if ({rx_b[2], rx_b[3]} !== 16'hAABB) begin n_err++; $display("FAIL wrap_read got=%h%h exp=AABB", rx_b[2], rx_b[3]); end
  endtask

  task automatic test_id_ignore();
    obs_wr.delete();
    txn_b = '{8'h9F, 8'h00, 8'hFF, 8'h3C};
    spi_txn(); model_txn();
    for (int i = 1; i < 4; i++) begin
      n_cmp++; if (rx_b[i] !== 8'hA5) begin n_err++; $display("FAIL id_byte%0d got=%h exp=A5", i, rx_b[i]); end
    end
    txn_b = '{8'h55, 8'h02, 8'h00, 8'h12};
    spi_txn(); model_txn();
    for (int i = 1; i < 4; i++) begin
      n_cmp++; if (rx_b[i] !== 8'hFF) begin n_err++; $display("FAIL ignore_byte%0d got=%h exp=FF", i, rx_b[i]); end
    end
    n_cmp++; if (obs_wr.size() !== 0) begin n_err++; $display("FAIL ignore_no_wstb got=%0d exp=0", obs_wr.size()); end
  endtask

  task automatic test_abort();
    logic [7:0] r;
    logic m;
    obs_wr.delete();
    bus.nSS = 1'b0;
    wait_clk(6);
    send_byte(8'h02, r);
    send_byte(8'h07, r);
    for (int i = 0; i < 4; i++) send_bit(i[0], m);
    wait_clk(6);
    bus.nSS = 1'b1;
    wait_clk(2);
    n_cmp++; if (bus.MISO_OE !== 1'b1) begin n_err++; $display("FAIL abort_oe_2clk got=%b exp=1", bus.MISO_OE); end
    wait_clk(1);
    n_cmp++; if ({bus.MISO_OE, bus.MISO} !== 2'b01) begin n_err++; $display("FAIL abort_oe_3clk got=%b exp=01", {bus.MISO_OE, bus.MISO}); end
    wait_clk(8);
    n_cmp++; if (obs_wr.size() !== 0) begin n_err++; $display("FAIL abort_no_wstb got=%0d exp=0", obs_wr.size()); end
    bus.LADDR = 4'd7; #1;
    n_cmp++; if (bus.LDATA !== mem_m[7]) begin n_err++; $display("FAIL abort_reg7 got=%h exp=%h", bus.LDATA, mem_m[7]); end
    @(negedge clk);
  endtask

  task automatic test_random();
    int kind;
    int len;
    int bad;
    for (int t = 0; t < 12; t++) begin
      obs_wr.delete(); exp_wr.delete(); unstable = 0;
      txn_b.delete();
      kind = $urandom_range(0, 4);
      len = $urandom_range(1, 4);
      case (kind)
        0: txn_b.push_back(8'h02);
        1: txn_b.push_back(8'h03);
        2: txn_b.push_back(8'h9F);
        3: txn_b.push_back(8'h10 + 8'($urandom_range(0, 15)));
        default: txn_b.push_back((t % 2 == 0) ? 8'h02 : 8'h03);
      endcase
      if (kind != 4) begin
        txn_b.push_back(8'($urandom));
        for (int i = 0; i < len; i++) txn_b.push_back(8'($urandom));
      end
      spi_txn(); model_txn();
      n_cmp++; if (obs_wr.size() !== exp_wr.size()) begin n_err++; $display("FAIL rand%0d_wcount got=%0d exp=%0d", t, obs_wr.size(), exp_wr.size()); end
      else begin
        foreach (exp_wr[i]) begin
          n_cmp++; if (obs_wr[i] !== exp_wr[i]) begin n_err++; $display("FAIL rand%0d_write%0d got=%h exp=%h", t, i, obs_wr[i], exp_wr[i]); end
        end
      end
      foreach (exp_rx[i]) begin
        if (exp_chk[i]) begin
          n_cmp++; if (rx_b[i] !== exp_rx[i]) begin n_err++; $display("FAIL rand%0d_miso%0d got=%h exp=%h", t, i, rx_b[i], exp_rx[i]); end
        end
      end
      n_cmp++; if (unstable !== 0) begin n_err++; $display("FAIL rand%0d_stable got=%0d exp=0", t, unstable); end
      bad = 0;
      for (int a = 0; a < 16; a++) begin
        bus.LADDR = a[3:0]; #1;
        if (bus.LDATA !== mem_m[a]) bad++;
      end
      n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL rand%0d_regfile got=%0d bad exp=0", t, bad); end
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.nSS = 1'b1; bus.SCK = 1'b0; bus.MOSI = 1'b0; bus.LADDR = 4'd0;
    @(negedge clk);
    test_reset();
    test_reset_mid();
    test_write_basic();
    test_read_basic();
    test_wrap();
    test_id_ignore();
    test_abort();
    test_random();
    n_cmp++; if (wstb_wide !== 0) begin n_err++; $display("FAIL wstb_width got=%0d multi-cycle exp=0", wstb_wide); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
